// File: rtl/ebi_tx_vc_sched.sv
// +----------------------------------------------------------------------------+
// | ebi_tx_vc_sched : credit-based round-robin VC scheduler and frame sequencer |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ebi_tx_vc_sched #(
    parameter int CHANNEL_NUM       = 4,
    parameter int CHANNEL_NUM_WIDTH = 2,
    parameter int MAX_MESSAGE_WIDTH = 8,
    parameter logic [CHANNEL_NUM-1:0][MAX_MESSAGE_WIDTH-1:0] CHANNEL_LENGTH_LIST =
        {CHANNEL_NUM{MAX_MESSAGE_WIDTH'(8)}},
    parameter int CREDIT_INIT       = 2,
    parameter int CREDIT_WIDTH      = 3
) (
    input  logic                         bus_clk,
    input  logic                         rst,
    input  logic [CHANNEL_NUM-1:0]       ch_req_i,
    output logic [CHANNEL_NUM-1:0]       ch_pop_o,
    input  logic                         credit_ret_valid_i,
    input  logic [CHANNEL_NUM_WIDTH-1:0] credit_ret_vc_i,
    output logic [1:0]                   phase_o,
    output logic [CHANNEL_NUM_WIDTH-1:0] tx_vc_o,
    output logic [MAX_MESSAGE_WIDTH-1:0] bit_idx_o,
    output logic [CHANNEL_NUM-1:0]       credit_avail_o,
    output logic                         credit_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        VCID  = 2'd2,
        DATA  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [CHANNEL_NUM_WIDTH-1:0]   tx_vc_q, tx_vc_d;
    logic [CHANNEL_NUM_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MAX_MESSAGE_WIDTH-1:0]   bit_idx_q, bit_idx_d;
    logic                           err_q, err_d;

    logic [CHANNEL_NUM-1:0]         w_eligible;
    logic [CHANNEL_NUM-1:0]         w_ovf;
    logic                           w_grant_valid;
    logic [CHANNEL_NUM_WIDTH-1:0]   w_grant_idx;
    logic [CHANNEL_NUM_WIDTH-1:0]   w_idx;
    logic                           w_found;

    assign w_eligible = ch_req_i & credit_avail_o;

    // Rotating priority: first eligible channel at or after rr_ptr_q.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            w_idx = CHANNEL_NUM_WIDTH'((int'(rr_ptr_q) + k) % CHANNEL_NUM);
            if (!w_found && w_eligible[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_vc_d       = tx_vc_q;
        rr_ptr_d      = rr_ptr_q;
        bit_idx_d     = bit_idx_q;
        w_grant_valid = 1'b0;
        ch_pop_o      = '0;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    w_grant_valid = 1'b1;
                    tx_vc_d       = w_grant_idx;
                    bit_idx_d     = '0;
                    state_d       = START;
                end
            end
            START: begin
                bit_idx_d = MAX_MESSAGE_WIDTH'(CHANNEL_NUM_WIDTH - 1);
                state_d   = VCID;
            end
            VCID: begin
                if (bit_idx_q == '0) begin
                    state_d = DATA;
                end else begin
                    bit_idx_d = bit_idx_q - MAX_MESSAGE_WIDTH'(1);
                end
            end
            DATA: begin
                if (bit_idx_q == CHANNEL_LENGTH_LIST[tx_vc_q] - MAX_MESSAGE_WIDTH'(1)) begin
                    ch_pop_o[tx_vc_q] = 1'b1;
                    rr_ptr_d  = (tx_vc_q == CHANNEL_NUM_WIDTH'(CHANNEL_NUM - 1)) ?
                                '0 : tx_vc_q + CHANNEL_NUM_WIDTH'(1);
                    bit_idx_d = '0;
                    state_d   = IDLE;
                end else begin
                    bit_idx_d = bit_idx_q + MAX_MESSAGE_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_vc_q   <= '0;
            rr_ptr_q  <= '0;
            bit_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_vc_q   <= tx_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            bit_idx_q <= bit_idx_d;
            err_q     <= err_d;
        end
    end

    assign err_d = err_q | (|w_ovf);

    for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_credit
        logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
        logic                    grant_w, ret_w;

        assign grant_w   = w_grant_valid && (w_grant_idx == CHANNEL_NUM_WIDTH'(gi));
        assign ret_w     = credit_ret_valid_i && (credit_ret_vc_i == CHANNEL_NUM_WIDTH'(gi));
        // A simultaneous grant cancels the return, so it can never overflow.
        assign w_ovf[gi] = ret_w && !grant_w && (credit_q == CREDIT_WIDTH'(CREDIT_INIT));

        always_comb begin
            credit_d = credit_q;
            if (grant_w && !ret_w) begin
                credit_d = credit_q - CREDIT_WIDTH'(1);
            end else if (ret_w && !grant_w && !w_ovf[gi]) begin
                credit_d = credit_q + CREDIT_WIDTH'(1);
            end
        end

        always_ff @(posedge bus_clk) begin
            if (rst) begin
                credit_q <= CREDIT_WIDTH'(CREDIT_INIT);
            end else begin
                credit_q <= credit_d;
            end
        end

        assign credit_avail_o[gi] = |credit_q;
    end

    assign phase_o      = state_q;
    assign tx_vc_o      = tx_vc_q;
    assign bit_idx_o    = bit_idx_q;
    assign credit_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ebi_tx_vc_sched.sv
// +----------------------------------------------------------------------------+
// | tb_ebi_tx_vc_sched : directed self-checking bench for ebi_tx_vc_sched       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ebi_tx_vc_sched;

    logic       bus_clk = 1'b0;
    logic       rst;
    logic [3:0] ch_req;
    logic [3:0] ch_pop;
    logic       ret_valid;
    logic [1:0] ret_vc;
    logic [1:0] phase;
    logic [1:0] tx_vc;
    logic [7:0] bit_idx;
    logic [3:0] avail;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 bus_clk = ~bus_clk;

    ebi_tx_vc_sched dut (
        .bus_clk            (bus_clk),
        .rst                (rst),
        .ch_req_i           (ch_req),
        .ch_pop_o           (ch_pop),
        .credit_ret_valid_i (ret_valid),
        .credit_ret_vc_i    (ret_vc),
        .phase_o            (phase),
        .tx_vc_o            (tx_vc),
        .bit_idx_o          (bit_idx),
        .credit_avail_o     (avail),
        .credit_err_o       (err)
    );

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ch_req    = '0;
        ret_valid = 1'b0;
        ret_vc    = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_phase(input logic [1:0] p, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < 100) begin
            if (phase == p) ok = 1'b1;
            else begin
                step();
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_req = 4'hF; ret_valid = 1'b0; ret_vc = '0;
        step();
        step();
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_checks++; if (tx_vc !== 2'd0) begin n_fail++; $display("FAIL reset_tx_vc: got %0d expected 0", tx_vc); end
        n_checks++; if (bit_idx !== 8'd0) begin n_fail++; $display("FAIL reset_bit_idx: got %0d expected 0", bit_idx); end
        n_checks++; if (ch_pop !== 4'h0) begin n_fail++; $display("FAIL reset_pop: got %h expected 0", ch_pop); end
        n_checks++; if (avail !== 4'hF) begin n_fail++; $display("FAIL reset_avail: got %h expected f", avail); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err); end
        rst = 1'b0; ch_req = '0;
    endtask

    task automatic test_single();
        int         pos;
        logic [1:0] ep;
        logic [7:0] eb;
        logic [3:0] epop;
        do_reset();
        ch_req = 4'b0001;
        for (int k = 0; k < 28; k++) begin
            step();
            pos  = k % 12;
            ep   = 2'd0;
            eb   = 8'd0;
            epop = 4'b0000;
            if (k < 24) begin
                if (pos == 0)       ep = 2'd1;
                else if (pos <= 2)  ep = 2'd2;
                else if (pos <= 10) ep = 2'd3;
                if (pos == 1) eb = 8'd1;
                if (pos >= 3 && pos <= 10) eb = 8'(pos - 3);
                if (pos == 10) epop = 4'b0001;
            end
            n_checks++; if (phase !== ep) begin n_fail++; $display("FAIL single_phase[%0d]: got %0d expected %0d", k, phase, ep); end
            n_checks++; if (bit_idx !== eb) begin n_fail++; $display("FAIL single_bit_idx[%0d]: got %0d expected %0d", k, bit_idx, eb); end
            n_checks++; if (ch_pop !== epop) begin n_fail++; $display("FAIL single_pop[%0d]: got %h expected %h", k, ch_pop, epop); end
        end
        n_checks++; if (avail !== 4'b1110) begin n_fail++; $display("FAIL single_avail: got %b expected 1110", avail); end
        ch_req = '0;
    endtask

    task automatic test_round_robin();
        bit         ok;
        logic [1:0] exp_vc;
        do_reset();
        ch_req = 4'hF;
        for (int f = 0; f < 5; f++) begin
            exp_vc = 2'(f % 4);
            wait_phase(2'd1, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_start_timeout[%0d]: got none expected start", f); end
            n_checks++; if (tx_vc !== exp_vc) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", f, tx_vc, exp_vc); end
            ret_valid = 1'b1; ret_vc = exp_vc;
            step();
            ret_valid = 1'b0;
            wait_phase(2'd0, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_end_timeout[%0d]: got none expected idle", f); end
        end
        ch_req = '0;
        step();
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL rr_final_phase: got %0d expected 0", phase); end
        n_checks++; if (avail !== 4'hF) begin n_fail++; $display("FAIL rr_final_avail: got %h expected f", avail); end
    endtask

    task automatic test_credit_block();
        bit ok;
        do_reset();
        ch_req = 4'b0100;
        for (int f = 0; f < 2; f++) begin
            wait_phase(2'd1, ok);
            wait_phase(2'd0, ok);
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL blk_drain_timeout: got none expected idle"); end
        step();
        step();
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL blk_idle: got %0d expected 0", phase); end
        n_checks++; if (avail !== 4'b1011) begin n_fail++; $display("FAIL blk_avail: got %b expected 1011", avail); end
        ret_valid = 1'b1; ret_vc = 2'd2;
        step();
        ret_valid = 1'b0;
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL blk_ret_phase: got %0d expected 0", phase); end
        n_checks++; if (avail !== 4'hF) begin n_fail++; $display("FAIL blk_ret_avail: got %b expected 1111", avail); end
        step();
        n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL blk_release_phase: got %0d expected 1", phase); end
        n_checks++; if (tx_vc !== 2'd2) begin n_fail++; $display("FAIL blk_release_vc: got %0d expected 2", tx_vc); end
        ch_req = '0;
        wait_phase(2'd0, ok);
    endtask

    task automatic test_simul_grant_return();
        bit ok;
        do_reset();
        ch_req = 4'b1000;
        wait_phase(2'd1, ok);
        ch_req = '0;
        wait_phase(2'd0, ok);
        n_checks++; if (avail !== 4'hF) begin n_fail++; $display("FAIL sim_pre_avail: got %b expected 1111", avail); end
        ch_req = 4'b1000; ret_valid = 1'b1; ret_vc = 2'd3;
        step();
        ch_req = '0; ret_valid = 1'b0;
        n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL sim_phase: got %0d expected 1", phase); end
        n_checks++; if (tx_vc !== 2'd3) begin n_fail++; $display("FAIL sim_vc: got %0d expected 3", tx_vc); end
        n_checks++; if (avail !== 4'hF) begin n_fail++; $display("FAIL sim_avail: got %b expected 1111", avail); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sim_err: got %0d expected 0", err); end
        wait_phase(2'd0, ok);
        ch_req = 4'b1000;
        wait_phase(2'd1, ok);
        ch_req = '0;
        n_checks++; if (avail !== 4'b0111) begin n_fail++; $display("FAIL sim_drain_avail: got %b expected 0111", avail); end
        wait_phase(2'd0, ok);
    endtask

    task automatic test_over_return();
        int starts;
        do_reset();
        ret_valid = 1'b1; ret_vc = 2'd1;
        step();
        ret_valid = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovr_err: got %0d expected 1", err); end
        n_checks++; if (avail !== 4'hF) begin n_fail++; $display("FAIL ovr_avail: got %b expected 1111", avail); end
        ch_req = 4'b0010;
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (phase == 2'd1) starts++;
        end
        ch_req = '0;
        n_checks++; if (starts != 2) begin n_fail++; $display("FAIL ovr_frames: got %0d expected 2", starts); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovr_err_sticky: got %0d expected 1", err); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovr_err_clear: got %0d expected 0", err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int i;
        do_reset();
        ch_req = 4'b0001;
        wait_phase(2'd1, ok);
        ch_req = 4'b0011;
        wait_phase(2'd0, ok);
        i = 0;
        while (!(phase == 2'd3 && bit_idx == 8'd3) && i < 100) begin
            step();
            i++;
        end
        n_checks++; if (i >= 100) begin n_fail++; $display("FAIL mid_timeout: got none expected data bit 3"); end
        n_checks++; if (tx_vc !== 2'd1) begin n_fail++; $display("FAIL mid_vc: got %0d expected 1", tx_vc); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL mid_phase: got %0d expected 0", phase); end
        n_checks++; if (ch_pop !== 4'h0) begin n_fail++; $display("FAIL mid_pop: got %h expected 0", ch_pop); end
        n_checks++; if (bit_idx !== 8'd0) begin n_fail++; $display("FAIL mid_bit_idx: got %0d expected 0", bit_idx); end
        n_checks++; if (tx_vc !== 2'd0) begin n_fail++; $display("FAIL mid_tx_vc: got %0d expected 0", tx_vc); end
        n_checks++; if (avail !== 4'hF) begin n_fail++; $display("FAIL mid_avail: got %b expected 1111", avail); end
        step();
        n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL mid_restart_phase: got %0d expected 1", phase); end
        n_checks++; if (tx_vc !== 2'd0) begin n_fail++; $display("FAIL mid_rr_reset: got %0d expected 0", tx_vc); end
        ch_req = '0;
        wait_phase(2'd0, ok);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_credit_block();
        test_simul_grant_return();
        test_over_return();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
